// File: rtl/jt7759_dbuf_if.sv
// Signal bundle between jt7759_dbuf and its surroundings (controller, ROM, host).
// The buffer itself uses the slave modport; whatever drives it uses master.
interface jt7759_dbuf_if #(
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  // global qualifiers
  logic          cen_ctl;
  logic          mdn;
  // controller side
  logic          ctrl_cs;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_din;
  logic          ctrl_ok;
  // ROM side
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  // host side
  logic          cs;
  logic          wrn;
  logic [DW-1:0] din;
  logic          drqn;
  // status
  logic [LW-1:0] level;
  logic          ovf;

  modport slave (
    input  cen_ctl, mdn, ctrl_cs, ctrl_addr, rom_data, rom_ok, cs, wrn, din,
    output ctrl_din, ctrl_ok, rom_cs, rom_addr, drqn, level, ovf
  );

  modport master (
    output cen_ctl, mdn, ctrl_cs, ctrl_addr, rom_data, rom_ok, cs, wrn, din,
    input  ctrl_din, ctrl_ok, rom_cs, rom_addr, drqn, level, ovf
  );
endinterface

// File: rtl/jt7759_dbuf.sv
// DEPTH-entry data FIFO feeding the JT7759 decoder control.
// Master mode (mdn=1): prefetches sequential ROM bytes ahead of the controller.
// Slave mode  (mdn=0): queues host writes and paces the host through drqn.
module jt7759_dbuf #(
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic          rst,
  input  logic          clk,
  jt7759_dbuf_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD);

  typedef enum logic [1:0] {
    ST_IDLE,    // no ROM access: FIFO full or slave mode
    ST_SETTLE,  // address presented, rom_ok not trusted yet
    ST_WAIT     // waiting for rom_ok to push the byte
  } fetch_t;

  fetch_t state, state_nx;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level, level_nx;
  logic [AW-1:0] head_addr;   // address of the byte at the FIFO head
  logic [AW-1:0] fetch_ptr;   // address of the next byte to fetch from ROM
  logic [HW-1:0] hold;
  logic          last_wrn;
  logic          last_mdn;
  logic          ovf;

  logic          full, empty;
  logic          mode_flush, miss, flush;
  logic          ctrl_ok, pop;
  logic          host_wr, rom_push, push;
  logic [DW-1:0] push_data;

  assign full       = (level == FULL_LVL);
  assign empty      = (level == '0);
  assign mode_flush = (bus.mdn != last_mdn);

  // A request misses when the head (or, if empty, the next fetch) is not the
  // byte the controller wants; the FIFO is then restarted at ctrl_addr.
  assign miss = bus.mdn & bus.ctrl_cs &
                (empty ? (fetch_ptr != bus.ctrl_addr) : (head_addr != bus.ctrl_addr));
  assign flush = mode_flush | miss;

  // In slave mode the controller takes bytes in order, whatever its address.
  assign ctrl_ok = bus.ctrl_cs & ~empty & ~mode_flush &
                   (~bus.mdn | (head_addr == bus.ctrl_addr));
  assign pop     = ctrl_ok;

  // Host write is the first cycle wrn is seen low while selected.
  assign host_wr   = ~bus.mdn & bus.cs & ~bus.wrn & last_wrn;
  assign rom_push  = bus.mdn & (state == ST_WAIT) & bus.rom_ok;
  assign push      = (host_wr | rom_push) & (~full | pop) & ~flush;
  assign push_data = bus.mdn ? bus.rom_data : bus.din;

  assign bus.ctrl_ok  = ctrl_ok;
  assign bus.ctrl_din = mem[rd_ptr];
  assign bus.rom_cs   = bus.mdn & (state != ST_IDLE);
  assign bus.rom_addr = fetch_ptr;
  assign bus.drqn     = bus.mdn | ~(bus.ctrl_cs & ~full & (hold == '0));
  assign bus.level    = level;
  assign bus.ovf      = ovf;

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip the assignment infer a latch.
    level_nx = level;
    if (flush)
      level_nx = '0;
    else if (push && !pop)
      level_nx = level + LW'(1);
    else if (pop && !push)
      level_nx = level - LW'(1);
  end

  // Fetch FSM next state: flushes restart the fetch, full FIFO parks it.
  always_comb begin
    state_nx = state;
    if (mode_flush || !bus.mdn)
      state_nx = ST_IDLE;
    else if (miss)
      state_nx = ST_SETTLE;
    else begin
      case (state)
        ST_IDLE:   if (!(full && !pop)) state_nx = ST_SETTLE;
        ST_SETTLE: state_nx = ST_WAIT;
        ST_WAIT:   if (bus.rom_ok) state_nx = (level_nx == FULL_LVL) ? ST_IDLE : ST_SETTLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // FIFO storage, pointers, address tracking, host pacing and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset on purpose so ctrl_din reads 0 out of reset;
      // a plain RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      head_addr <= '0;
      fetch_ptr <= '0;
      hold      <= '0;
      last_wrn  <= 1'b1;
      last_mdn  <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      last_wrn <= bus.wrn;
      last_mdn <= bus.mdn;
      level    <= level_nx;

      // a host write that could not be pushed was dropped on a full FIFO
      if (host_wr && !push && !flush) ovf <= 1'b1;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end

      if (miss) begin
        head_addr <= bus.ctrl_addr;
        fetch_ptr <= bus.ctrl_addr;
      end else begin
        if (pop)             head_addr <= head_addr + AW'(1);
        if (rom_push && push) fetch_ptr <= fetch_ptr + AW'(1);
      end

      if (mode_flush)
        hold <= '0;
      else if (host_wr && push)
        hold <= HOLD_LD;
      else if (bus.cen_ctl && hold != '0)
        hold <= hold - HW'(1);
    end
  end
endmodule

// File: tb/tb_jt7759_dbuf.sv
// Directed bench for jt7759_dbuf: expected controller bytes are queued when
// the stimulus is issued and compared whenever a transfer takes place.
module tb_jt7759_dbuf;
  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic rst;
  bit   rom_ok_en;

  int             n_tests;
  int             n_fail;
  int             cyc_n;
  bit             xfer;
  logic [DW-1:0]  exp_q[$];
  logic [AW-1:0]  rom_seq[$];

  always #5 clk = ~clk;

  jt7759_dbuf_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  jt7759_dbuf #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus.slave)
  );

  // ROM model: each byte holds the low 8 bits of its address.
  assign bus.rom_data = bus.rom_addr[7:0];
  assign bus.rom_ok   = rom_ok_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    xfer = 1'b0;
    if (bus.rom_cs && (rom_seq.size() == 0 || rom_seq[$] != bus.rom_addr))
      rom_seq.push_back(bus.rom_addr);
    if (bus.ctrl_cs && bus.ctrl_ok) begin
      xfer = 1'b1;
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pop_unexpected: observed %0h expected no transfer", bus.ctrl_din);
      end
      if (exp_q.size() != 0) check("pop_data", 32'(bus.ctrl_din), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    cyc_n++;
    bus.cen_ctl = (cyc_n % 4 == 3);
  endtask

  // Request one byte and check how many cycles the transfer took.
  task automatic request(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                         input int lat, input string tag);
    int n;
    n = 0;
    exp_q.push_back(exp);
    bus.ctrl_cs   = 1'b1;
    bus.ctrl_addr = addr;
    do begin
      cyc();
      n++;
    end while (!xfer && n < 20);
    bus.ctrl_cs = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int n;
    n_tests = 0;
    n_fail  = 0;
    cyc_n   = 0;
    rst           = 1'b1;
    rom_ok_en     = 1'b1;
    bus.cen_ctl   = 1'b0;
    bus.mdn       = 1'b1;
    bus.ctrl_cs   = 1'b0;
    bus.ctrl_addr = '0;
    bus.cs        = 1'b0;
    bus.wrn       = 1'b1;
    bus.din       = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    check("rst_ctrl_ok",  32'(bus.ctrl_ok),  0);
    check("rst_ctrl_din", 32'(bus.ctrl_din), 0);
    check("rst_rom_cs",   32'(bus.rom_cs),   0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_drqn",     32'(bus.drqn),     1);
    check("rst_level",    32'(bus.level),    0);
    check("rst_ovf",      32'(bus.ovf),      0);
    rst = 1'b0;

    // master sequential: only the first request misses
    for (int i = 0; i < 8; i++) begin
      request(AW'(32'h100 + i), DW'(i), (i == 0) ? 4 : 1, "seq");
      repeat (10) cyc();
      check("seq_level_full", 32'(bus.level), DEPTH);
    end

    // master miss: reload 0x100, then jump to 0x1F000 with a full FIFO
    request(17'h00100, 8'h00, 4, "reload");
    repeat (10) cyc();
    check("miss_pre_level", 32'(bus.level), DEPTH);
    bus.ctrl_cs   = 1'b1;
    bus.ctrl_addr = 17'h1F000;
    cyc();
    check("miss_level",    32'(bus.level),    0);
    check("miss_rom_cs",   32'(bus.rom_cs),   1);
    check("miss_rom_addr", 32'(bus.rom_addr), 32'h1F000);
    request(17'h1F000, 8'h00, 3, "miss");
    repeat (10) cyc();

    // address wrap at the top of the ROM
    rom_seq.delete();
    request(17'h1FFFE, 8'hFE, 4, "wrap0");
    repeat (10) cyc();
    request(17'h1FFFF, 8'hFF, 1, "wrap1");
    repeat (10) cyc();
    request(17'h00000, 8'h00, 1, "wrap2");
    repeat (10) cyc();
    request(17'h00001, 8'h01, 1, "wrap3");
    repeat (10) cyc();
    check("wrap_seq_len", 32'(rom_seq.size() >= 4), 1);
    check("wrap_seq0", 32'(rom_seq[0]), 32'h1FFFE);
    check("wrap_seq1", 32'(rom_seq[1]), 32'h1FFFF);
    check("wrap_seq2", 32'(rom_seq[2]), 32'h00000);
    check("wrap_seq3", 32'(rom_seq[3]), 32'h00001);

    // mode switch with three bytes buffered
    rom_ok_en = 1'b0;
    request(17'h00002, 8'h02, 1, "pre_switch");
    check("switch_pre_level", 32'(bus.level), 3);
    bus.mdn = 1'b0;
    cyc();
    check("switch_level",  32'(bus.level),  0);
    check("switch_rom_cs", 32'(bus.rom_cs), 0);

    // slave pacing
    bus.ctrl_cs = 1'b1;
    cyc();
    check("pace_drqn_idle", 32'(bus.drqn), 0);
    bus.cs  = 1'b1;
    bus.din = 8'hA5;
    bus.wrn = 1'b0;
    exp_q.push_back(8'hA5);
    cyc();
    check("pace_drqn_hi", 32'(bus.drqn),     1);
    check("pace_ok",      32'(bus.ctrl_ok),  1);
    check("pace_din",     32'(bus.ctrl_din), 32'hA5);
    bus.wrn = 1'b1;
    bus.cs  = 1'b0;
    ticks = 0;
    n     = 0;
    while (bus.drqn && n < 40) begin
      if (bus.cen_ctl) ticks++;
      cyc();
      n++;
    end
    check("pace_ticks",    32'(ticks),    HOLD);
    check("pace_drqn_low", 32'(bus.drqn), 0);
    bus.ctrl_cs = 1'b0;

    // slave overflow: fifth write is dropped
    for (int i = 0; i < 5; i++) begin
      bus.cs  = 1'b1;
      bus.din = DW'(8'h11 * (i + 1));
      bus.wrn = 1'b0;
      if (i < DEPTH) exp_q.push_back(DW'(8'h11 * (i + 1)));
      cyc();
      bus.wrn = 1'b1;
      cyc();
    end
    bus.cs = 1'b0;
    check("ovf_level", 32'(bus.level), DEPTH);
    check("ovf_flag",  32'(bus.ovf),   1);
    bus.ctrl_cs = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    bus.ctrl_cs = 1'b0;
    check("ovf_drain_level", 32'(bus.level), 0);
    check("ovf_sticky",      32'(bus.ovf),   1);

    // reset in the middle of a ROM wait
    bus.mdn       = 1'b1;
    bus.ctrl_cs   = 1'b1;
    bus.ctrl_addr = 17'h00040;
    repeat (3) cyc();
    check("mid_rom_cs",   32'(bus.rom_cs),   1);
    check("mid_rom_addr", 32'(bus.rom_addr), 32'h40);
    bus.ctrl_cs = 1'b0;
    rom_ok_en   = 1'b1;
    rst         = 1'b1;
    #1;
    check("mid_rst_rom_cs",   32'(bus.rom_cs),   0);
    check("mid_rst_rom_addr", 32'(bus.rom_addr), 0);
    check("mid_rst_level",    32'(bus.level),    0);
    check("mid_rst_ovf",      32'(bus.ovf),      0);
    check("mid_rst_ctrl_ok",  32'(bus.ctrl_ok),  0);
    check("mid_rst_ctrl_din", 32'(bus.ctrl_din), 0);
    check("mid_rst_drqn",     32'(bus.drqn),     1);
    rom_ok_en = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("mid_no_push", 32'(bus.level), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
